// File: rtl/fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand-forwarding and load-use hazard unit. A shadow record of the last
// DEPTH in-flight register writes is kept (entry 0 = youngest). Every source
// operand in decode is looked up combinationally against that record. The
// youngest matching entry supplies the operand if its result is available.
// If that entry is still waiting for load data, decode is stalled.
//
// Ports
//   iClk          clock, all state updates on the rising edge
//   iReset        synchronous, active-high reset
//   iIssueValid   instruction enters EX this cycle
//   iIssueWrEn    that instruction writes a register
//   iIssueRd      its destination register
//   iIssueIsLoad  its result returns from memory LOAD_LAT cycles later
//   iIssueData    ALU result (ignored for loads)
//   iLoadValid    load data returning this cycle
//   iLoadData     returned load data
//   iSrcAddr      packed decode source addresses, operand k at [k*ADDR_W +: ADDR_W]
//   iRegData      packed register-file read data, same packing
//   oOperand      packed forwarded operands, same packing
//   oFwdHit       bit k = operand k came from an in-flight entry
//   oStall        load-use hazard: decode holds, issue is dropped
//   oLoadErr      sticky flag: load data missing or unexpected
//   oStallCount   saturating count of stall cycles
// ----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                        iClk,
    input  logic                        iReset,
    input  logic                        iIssueValid,
    input  logic                        iIssueWrEn,
    input  logic [ADDR_W-1:0]           iIssueRd,
    input  logic                        iIssueIsLoad,
    input  logic [DATA_W-1:0]           iIssueData,
    input  logic                        iLoadValid,
    input  logic [DATA_W-1:0]           iLoadData,
    input  logic [NUM_SRC*ADDR_W-1:0]   iSrcAddr,
    input  logic [NUM_SRC*DATA_W-1:0]   iRegData,
    output logic [NUM_SRC*DATA_W-1:0]   oOperand,
    output logic [NUM_SRC-1:0]          oFwdHit,
    output logic                        oStall,
    output logic                        oLoadErr,
    output logic [15:0]                 oStallCount
);

    localparam int DUE_IDX = LOAD_LAT - 1;

    logic              v_reg    [DEPTH];
    logic [ADDR_W-1:0] rd_reg   [DEPTH];
    logic [DATA_W-1:0] data_reg [DEPTH];
    logic              pend_reg [DEPTH];

    logic              v_next    [DEPTH];
    logic [ADDR_W-1:0] rd_next   [DEPTH];
    logic [DATA_W-1:0] data_next [DEPTH];
    logic              pend_next [DEPTH];

    logic               due;
    logic               issue_take;
    logic [NUM_SRC-1:0] pend_hit;

    // The entry that should receive load data on this edge.
    assign due        = v_reg[DUE_IDX] & pend_reg[DUE_IDX];
    // Register 0 is never recorded; a stalled issue becomes a bubble.
    assign issue_take = iIssueValid & iIssueWrEn & ~oStall & (iIssueRd != '0);

    // ------------------------------------------------------------------
    // Next-state of the shadow record: entry 0 takes the new issue, every
    // other entry takes its younger neighbour. Aging never freezes.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if (gi == 0) begin : g_head
            assign v_next[gi]    = issue_take;
            assign rd_next[gi]   = iIssueRd;
            assign data_next[gi] = iIssueData;
            assign pend_next[gi] = issue_take & iIssueIsLoad;
        end else begin : g_tail
            // The due entry picks up its load data as it moves from
            // LOAD_LAT-1 to LOAD_LAT. With LOAD_LAT == DEPTH the due entry
            // shifts out instead and no entry ever does this.
            localparam bit RET_HERE = (gi == LOAD_LAT);
            logic ret;
            assign ret           = RET_HERE & due & iLoadValid;
            assign v_next[gi]    = v_reg[gi-1];
            assign rd_next[gi]   = rd_reg[gi-1];
            assign data_next[gi] = ret ? iLoadData : data_reg[gi-1];
            assign pend_next[gi] = ret ? 1'b0 : pend_reg[gi-1];
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_reg[i]    <= 1'b0;
                rd_reg[i]   <= '0;
                data_reg[i] <= '0;
                pend_reg[i] <= 1'b0;
            end
            oLoadErr    <= 1'b0;
            oStallCount <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                v_reg[i]    <= v_next[i];
                rd_reg[i]   <= rd_next[i];
                data_reg[i] <= data_next[i];
                pend_reg[i] <= pend_next[i];
            end
            // Due without data, or data with nothing due.
            if (due ^ iLoadValid)
                oLoadErr <= 1'b1;
            if (oStall && (oStallCount != 16'hFFFF))
                oStallCount <= oStallCount + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-operand lookup. Scanning oldest to youngest lets the youngest
    // match overwrite older ones, so the lowest index wins.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [ADDR_W-1:0] src;
        logic              found;
        logic              found_pend;
        logic [DATA_W-1:0] found_data;

        assign src = iSrcAddr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            found      = 1'b0;
            found_pend = 1'b0;
            found_data = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (v_reg[i] && (rd_reg[i] == src) && (src != '0)) begin
                    found      = 1'b1;
                    found_pend = pend_reg[i];
                    found_data = data_reg[i];
                end
            end
        end

        assign oFwdHit[gi]  = found & ~found_pend;
        assign pend_hit[gi] = found & found_pend;
        assign oOperand[gi*DATA_W +: DATA_W] =
            (found & ~found_pend) ? found_data : iRegData[gi*DATA_W +: DATA_W];
    end

    assign oStall = |pend_hit;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the integer pipeline; successor of the fixed two-stage 32-bit forwarding mux. It keeps its own shadow record of the last DEPTH in-flight register writes and their results. For each of NUM_SRC source operands in decode, it selects the youngest matching in-flight result, or the register-file value if none matches. It stalls decode while a matching load result has not yet returned.

## Interface
- DATA_W, 32: operand/result width.
- ADDR_W, 5: register address width.
- NUM_SRC, 2: number of source operands looked up per cycle (1..4).
- DEPTH, 2: in-flight stages tracked (1..8). Covers every stage whose result is not yet readable from the register file.
- LOAD_LAT, 1: cycles from issue to load data return (1..DEPTH).
- iClk  in  1  clock; all state updates on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iIssueValid  in  1  an instruction enters EX this cycle.
- iIssueWrEn  in  1  that instruction writes a register.
- iIssueRd  in  ADDR_W  its destination register.
- iIssueIsLoad  in  1  its result comes from memory (LOAD_LAT later).
- iIssueData  in  DATA_W  ALU result (ignored for loads).
- iLoadValid  in  1  load data returning this cycle.
- iLoadData  in  DATA_W  returned load data.
- iSrcAddr  in  NUM_SRC*ADDR_W  decode source addresses, operand k at [k*ADDR_W +: ADDR_W].
- iRegData  in  NUM_SRC*DATA_W  register-file read data, same packing.
- oOperand  out  NUM_SRC*DATA_W  forwarded operands, same packing.
- oFwdHit  out  NUM_SRC  bit k = operand k taken from an in-flight entry.
- oStall  out  1  load-use hazard; decode must hold and issue must be dropped.
- oLoadErr  out  1  sticky: load data missing or unexpected.
- oStallCount  out  16  saturating count of stall cycles.

## Operation
- State: entry[0..DEPTH-1], each holding {v, rd, data, pend}. Entry 0 is the youngest.
- Each edge, all entries shift by one: entry[i+1] <= entry[i], and entry[DEPTH-1] is discarded. Shifting is unconditional, so stalls do not freeze aging.
- Entry 0 load, if iIssueValid & iIssueWrEn & ~oStall & iIssueRd != 0: v=1, rd=iIssueRd, pend=iIssueIsLoad, data=iIssueData (don't-care if pend).
- Entry 0 load otherwise: a bubble (v=0).
- Load return: the entry at index LOAD_LAT-1 with v&pend is "due".
  - If due and iLoadValid: data=iLoadData and pend=0 as it shifts to index LOAD_LAT.
  - If LOAD_LAT=DEPTH, the data retires and is never forwarded.
- Error: set oLoadErr on due & ~iLoadValid, or on iLoadValid with nothing due. In the due & ~iLoadValid case the entry keeps pend=1 until it shifts out.
- Lookup per operand k, combinational:
  - Match at entry i: v & rd==src_k & src_k!=0.
  - The lowest matching i wins.
  - If the winner has pend=0: oOperand_k=data and oFwdHit[k]=1.
  - If the winner has pend=1: oStall=1, oOperand_k=iRegData_k, oFwdHit[k]=0.
  - If no match: oOperand_k=iRegData_k and oFwdHit[k]=0.
- oStall = OR over operands of a pending winning match.
- oStallCount increments on every cycle with oStall=1 and saturates at 16'hFFFF.
- Register 0 is never recorded and never forwarded.

## Timing
- Reset (synchronous): all v=0, pend=0, data=0; oLoadErr=0; oStallCount=0.
  - Consequently, from the first cycle after reset: oStall=0, oFwdHit=0, oOperand=iRegData.
  - Reset mid-operation discards all in-flight entries and any pending load, with no error flagged.
- Capture latency: an issue captured at edge t is forwardable in cycle t+1 (at entry 0) through cycle t+DEPTH (at entry DEPTH-1).
- Loads: forwardable from cycle t+LOAD_LAT+1.
  - A consumer matching the load during cycles t+1..t+LOAD_LAT sees oStall=1.
  - A dependent instruction directly behind a LOAD_LAT=1 load stalls exactly one cycle.
- Lookup is combinational: iSrcAddr/iRegData to oOperand/oStall in the same cycle, with no register on the path.
- Simultaneous iIssueValid and oStall: the issue is dropped and a bubble enters.
- A return and a new issue in the same edge are independent. The return applies to the shifting entry; the issue goes into entry 0.
- Same rd in several entries: the youngest wins. A pending younger entry stalls even if an older entry is ready.
- iLoadValid in the same cycle as iReset is ignored.

## Test plan
- Back-to-back ALU forwarding (DEPTH=2):
  - Stimulus: issue r3=0x11 at t and r3=0x22 at t+1; src0=r3 at t+2.
  - Required: oOperand0=0x22 and oFwdHit=01.
  - At t+3, src0=r3 gives 0x22 (now at entry 1). At t+4 it gives iRegData.
- Load-use (LOAD_LAT=1):
  - Stimulus: issue load r5 at t; src1=r5 at t+1; iLoadValid with 0xDEAD at t+1.
  - Required: oStall=1 at t+1 only. At t+2, oOperand1=0xDEAD and oStall=0. oStallCount=1.
- Register 0 filter:
  - Stimulus: issue rd=0 with data 0xFFFF_FFFF; src0=0 with iRegData=0.
  - Required: oOperand0=0 and oFwdHit=0.
- Missing load return:
  - Stimulus: issue a load with no iLoadValid at the due cycle.
  - Required: oLoadErr rises next cycle and stays high.
  - Also: a stray iLoadValid with no load in flight sets oLoadErr.
- Reset mid-flight:
  - Stimulus: load r7 pending, assert iReset one cycle.
  - Required: next cycle oStall=0, oFwdHit=0, oOperand=iRegData, oStallCount=0, oLoadErr=0.
- Stall saturation:
  - Stimulus: force 0x1_0005 stall cycles (load never returns, LOAD_LAT=DEPTH).
  - Required: oStallCount holds 16'hFFFF.
